// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Command responder behind the uart FIFOs. It pops received bytes, decodes
//   register read/write frames, drives a simple register bus and pushes one
//   response byte per frame into the transmit FIFO.
//     'W' addr data -> register write, response 'K' (0x4B)
//     'R' addr      -> register read,  response = read data
//     other byte    -> discarded,      response '?' (0x3F), err_cnt + 1
//     gap > TIMEOUT mid-frame          response 'T' (0x54), err_cnt + 1
// Ports
//   clk_i        system clock
//   reset_i      synchronous active-high reset
//   rx_empty_i   rx FIFO empty; r_data_i valid whenever low
//   r_data_i     rx FIFO head byte (first-word-fall-through)
//   rd_uart_o    rx FIFO pop, asserted in the cycle a byte is consumed
//   tx_full_i    tx FIFO full
//   wr_uart_o    tx FIFO push of w_data_o
//   w_data_o     response byte
//   reg_addr_o   register bus address
//   reg_wdata_o  register bus write data
//   reg_we_o     register write strobe, one cycle
//   reg_re_o     register read strobe, one cycle
//   reg_rdata_i  register read data, valid one cycle after reg_re_o
//   busy_o       high whenever a frame or response is in progress
//   err_cnt_o    saturating count of bad commands and timeouts
module uart_reg_bridge #(
    parameter int unsigned TIMEOUT = 500000,
    parameter int unsigned TO_BIT  = 19
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_empty_i,
    input  logic [7:0] r_data_i,
    output logic       rd_uart_o,
    input  logic       tx_full_i,
    output logic       wr_uart_o,
    output logic [7:0] w_data_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o,
    output logic [7:0] err_cnt_o
);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_TO  = 8'h54;
    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_BUS_WR,
        S_BUS_RD,
        S_RD_WAIT,
        S_SEND
    } state_t;

    state_t            state_q;
    logic [7:0]        cmd_q;
    logic [7:0]        resp_q;
    logic [7:0]        reg_addr_q;
    logic [7:0]        reg_wdata_q;
    logic              reg_we_q;
    logic              reg_re_q;
    logic [7:0]        err_cnt_q;
    logic [TO_BIT-1:0] to_cnt_q;

    logic       rx_state;
    logic [7:0] err_inc;

    // Pop and capture happen in the same cycle, so the pop is decoded
    // directly from the registered state and the live empty flag.
    assign rx_state  = (state_q == S_IDLE) || (state_q == S_GET_ADDR) ||
                       (state_q == S_GET_DATA);
    assign rd_uart_o = rx_state && !rx_empty_i;

    // Push on the first SEND cycle the tx FIFO has room; leaving SEND on
    // the same edge makes it a single pulse.
    assign wr_uart_o = (state_q == S_SEND) && !tx_full_i;

    assign busy_o      = (state_q != S_IDLE);
    assign w_data_o    = resp_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;
    assign err_cnt_o   = err_cnt_q;

    // Error counter sticks at 0xFF.
    assign err_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Frame sequencer. Strobes are raised on the edge entering BUS_WR/BUS_RD
    // so they are high for exactly the cycle spent in those states.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            resp_q      <= 8'h00;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            err_cnt_q   <= 8'h00;
            to_cnt_q    <= '0;
        end else begin
            reg_we_q <= 1'b0;
            reg_re_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_empty_i) begin
                        cmd_q <= r_data_i;
                        if (r_data_i == CMD_WR || r_data_i == CMD_RD) begin
                            to_cnt_q <= '0;
                            state_q  <= S_GET_ADDR;
                        end else begin
                            resp_q    <= RSP_BAD;
                            err_cnt_q <= err_inc;
                            state_q   <= S_SEND;
                        end
                    end
                end
                S_GET_ADDR: begin
                    // A byte arriving on the expiry cycle still wins.
                    if (!rx_empty_i) begin
                        reg_addr_q <= r_data_i;
                        to_cnt_q   <= '0;
                        if (cmd_q == CMD_WR) begin
                            state_q <= S_GET_DATA;
                        end else begin
                            reg_re_q <= 1'b1;
                            state_q  <= S_BUS_RD;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        resp_q    <= RSP_TO;
                        err_cnt_q <= err_inc;
                        state_q   <= S_SEND;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_BIT'(1);
                    end
                end
                S_GET_DATA: begin
                    if (!rx_empty_i) begin
                        reg_wdata_q <= r_data_i;
                        to_cnt_q    <= '0;
                        reg_we_q    <= 1'b1;
                        state_q     <= S_BUS_WR;
                    end else if (to_cnt_q == TO_LAST) begin
                        resp_q    <= RSP_TO;
                        err_cnt_q <= err_inc;
                        state_q   <= S_SEND;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_BIT'(1);
                    end
                end
                S_BUS_WR: begin
                    resp_q  <= RSP_OK;
                    state_q <= S_SEND;
                end
                S_BUS_RD: begin
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Read data is valid exactly one cycle after the strobe.
                    resp_q  <= reg_rdata_i;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_full_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: models the rx/tx FIFOs and a register file,
// checks frame responses against a frame-level reference model.
module tb_uart_reg_bridge;

    localparam int unsigned TIMEOUT = 32;
    localparam int unsigned TO_BIT  = 6;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       rx_empty_i;
    logic [7:0] r_data_i;
    logic       rd_uart_o;
    logic       tx_full_i;
    logic       wr_uart_o;
    logic [7:0] w_data_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_rdata_i;
    logic       busy_o;
    logic [7:0] err_cnt_o;

    always #5 clk_i = ~clk_i;

    uart_reg_bridge #(.TIMEOUT(TIMEOUT), .TO_BIT(TO_BIT)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rx_empty_i  (rx_empty_i),
        .r_data_i    (r_data_i),
        .rd_uart_o   (rd_uart_o),
        .tx_full_i   (tx_full_i),
        .wr_uart_o   (wr_uart_o),
        .w_data_o    (w_data_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o),
        .err_cnt_o   (err_cnt_o)
    );

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] dev_mem[256];
    logic [7:0] ref_mem[256];
    int         ref_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0, we_cnt = 0, re_cnt = 0;
    int last_rd_cyc = 0, we_cyc = 0, re_cyc = 0, wr_cyc = 0;
    logic [7:0] we_addr, we_data;

    // One clock cycle of environment: observe outputs mid-cycle, let the edge
    // happen, then present new FIFO head / read data at the falling edge.
    task automatic tick();
        logic       re_now;
        logic [7:0] re_addr;
        #1;
        checks += 2;
        if (rd_uart_o && rx_empty_i) begin
            errors++;
            $display("FAIL rd_uart_on_empty cycle %0d: rd_uart=1 required 0", cyc);
        end
        if (wr_uart_o && tx_full_i) begin
            errors++;
            $display("FAIL wr_uart_on_full cycle %0d: wr_uart=1 required 0", cyc);
        end
        if (rd_uart_o && rxq.size() > 0) begin
            void'(rxq.pop_front());
            rd_cnt++;
            last_rd_cyc = cyc;
        end
        if (wr_uart_o) begin
            txq.push_back(w_data_o);
            wr_cyc = cyc;
        end
        if (reg_we_o) begin
            dev_mem[reg_addr_o] = reg_wdata_o;
            we_cnt++;
            we_cyc  = cyc;
            we_addr = reg_addr_o;
            we_data = reg_wdata_o;
        end
        re_now  = reg_re_o;
        re_addr = reg_addr_o;
        if (re_now) begin
            re_cnt++;
            re_cyc = cyc;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        rx_empty_i  = (rxq.size() == 0);
        r_data_i    = rx_empty_i ? 8'($urandom) : rxq[0];
        reg_rdata_i = re_now ? dev_mem[re_addr] : 8'($urandom);
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        rx_empty_i = 1'b0;
        r_data_i   = rxq[0];
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (txq.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (txq.size() >= n);
    endtask

    function automatic logic [7:0] bad_byte();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
        return b;
    endfunction

    task automatic test_reset();
        reset_i = 1'b1;
        ticks(2);
        checks++;
        if ({rd_uart_o, wr_uart_o, reg_we_o, reg_re_o, busy_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 00000",
                     {rd_uart_o, wr_uart_o, reg_we_o, reg_re_o, busy_o});
        end
        checks++;
        if ({w_data_o, reg_addr_o, reg_wdata_o, err_cnt_o} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 00000000",
                     {w_data_o, reg_addr_o, reg_wdata_o, err_cnt_o});
        end
        reset_i = 1'b0;
        ref_err = 0;
        ticks(2);
    endtask

    task automatic test_write();
        logic [7:0] a, d, got;
        int we0;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 8'h05 : 8'($urandom);
            d = (i == 0) ? 8'hA3 : 8'($urandom);
            we0 = we_cnt;
            txq.delete();
            push(8'h57); push(a); push(d);
            ref_mem[a] = d;
            wait_tx(1, 20, ok);
            got = ok ? txq[0] : 8'hxx;
            checks++;
            if (got !== 8'h4B) begin
                errors++;
                $display("FAIL write_resp: got %h required 4b", got);
            end
            checks++;
            if (we_cnt - we0 !== 1 || we_addr !== a || we_data !== d) begin
                errors++;
                $display("FAIL write_bus: strobes %0d addr %h data %h required 1 %h %h",
                         we_cnt - we0, we_addr, we_data, a, d);
            end
            checks++;
            if (we_cyc - last_rd_cyc !== 1 || wr_cyc - last_rd_cyc !== 2) begin
                errors++;
                $display("FAIL write_latency: we +%0d wr +%0d required +1 +2",
                         we_cyc - last_rd_cyc, wr_cyc - last_rd_cyc);
            end
            checks++;
            if (busy_o !== 1'b0 || err_cnt_o !== 8'(ref_err)) begin
                errors++;
                $display("FAIL write_after: busy %b err %h required 0 %h",
                         busy_o, err_cnt_o, 8'(ref_err));
            end
        end
    endtask

    task automatic test_read();
        logic [7:0] a, got;
        int re0, we0;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 8'h05 : 8'($urandom);
            re0 = re_cnt;
            we0 = we_cnt;
            txq.delete();
            push(8'h52); push(a);
            wait_tx(1, 20, ok);
            got = ok ? txq[0] : 8'hxx;
            checks++;
            if (got !== ref_mem[a]) begin
                errors++;
                $display("FAIL read_resp addr %h: got %h required %h", a, got, ref_mem[a]);
            end
            checks++;
            if (re_cnt - re0 !== 1 || we_cnt !== we0) begin
                errors++;
                $display("FAIL read_bus: re %0d we %0d required 1 0", re_cnt - re0, we_cnt - we0);
            end
            checks++;
            if (re_cyc - last_rd_cyc !== 1 || wr_cyc - last_rd_cyc !== 3) begin
                errors++;
                $display("FAIL read_latency: re +%0d wr +%0d required +1 +3",
                         re_cyc - last_rd_cyc, wr_cyc - last_rd_cyc);
            end
            checks++;
            if (err_cnt_o !== 8'(ref_err)) begin
                errors++;
                $display("FAIL read_errcnt: got %h required %h", err_cnt_o, 8'(ref_err));
            end
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] b, got;
        int rd0, we0, re0;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'h41 : bad_byte();
            rd0 = rd_cnt; we0 = we_cnt; re0 = re_cnt;
            txq.delete();
            push(b);
            ref_err = (ref_err < 255) ? ref_err + 1 : 255;
            wait_tx(1, 20, ok);
            got = ok ? txq[0] : 8'hxx;
            checks++;
            if (got !== 8'h3F) begin
                errors++;
                $display("FAIL bad_resp cmd %h: got %h required 3f", b, got);
            end
            checks++;
            if (rd_cnt - rd0 !== 1 || we_cnt !== we0 || re_cnt !== re0) begin
                errors++;
                $display("FAIL bad_bus: rd %0d we %0d re %0d required 1 0 0",
                         rd_cnt - rd0, we_cnt - we0, re_cnt - re0);
            end
            checks++;
            if (err_cnt_o !== 8'(ref_err)) begin
                errors++;
                $display("FAIL bad_errcnt: got %h required %h", err_cnt_o, 8'(ref_err));
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] got, a, d;
        int we0;
        bit ok;
        // Stall in GET_DATA.
        we0 = we_cnt;
        txq.delete();
        push(8'h57); push(8'h05);
        ticks(2 + TIMEOUT / 2);
        checks++;
        if (busy_o !== 1'b1 || txq.size() !== 0) begin
            errors++;
            $display("FAIL timeout_early: busy %b tx %0d required 1 0", busy_o, txq.size());
        end
        wait_tx(1, TIMEOUT + 10, ok);
        ref_err = (ref_err < 255) ? ref_err + 1 : 255;
        got = ok ? txq[0] : 8'hxx;
        checks++;
        if (got !== 8'h54 || we_cnt !== we0) begin
            errors++;
            $display("FAIL timeout_data: resp %h we %0d required 54 0", got, we_cnt - we0);
        end
        checks++;
        if (err_cnt_o !== 8'(ref_err) || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_data_after: err %h busy %b required %h 0",
                     err_cnt_o, busy_o, 8'(ref_err));
        end
        // Stall in GET_ADDR.
        txq.delete();
        push(8'h52);
        wait_tx(1, TIMEOUT + 10, ok);
        ref_err = (ref_err < 255) ? ref_err + 1 : 255;
        got = ok ? txq[0] : 8'hxx;
        checks++;
        if (got !== 8'h54 || err_cnt_o !== 8'(ref_err)) begin
            errors++;
            $display("FAIL timeout_addr: resp %h err %h required 54 %h",
                     got, err_cnt_o, 8'(ref_err));
        end
        // Normal read afterwards.
        txq.delete();
        push(8'h52); push(8'h05);
        wait_tx(1, 20, ok);
        got = ok ? txq[0] : 8'hxx;
        checks++;
        if (got !== ref_mem[8'h05]) begin
            errors++;
            $display("FAIL timeout_recover: got %h required %h", got, ref_mem[8'h05]);
        end
        // Slow but in-time bytes: each consumed byte restarts the window.
        a = 8'($urandom); d = 8'($urandom);
        txq.delete();
        push(8'h57); ticks(TIMEOUT - 4);
        push(a);     ticks(TIMEOUT - 4);
        checks++;
        if (txq.size() !== 0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL slow_frame_midway: tx %0d busy %b required 0 1", txq.size(), busy_o);
        end
        push(d);
        ref_mem[a] = d;
        wait_tx(1, 20, ok);
        got = ok ? txq[0] : 8'hxx;
        checks++;
        if (got !== 8'h4B || dev_mem[a] !== d) begin
            errors++;
            $display("FAIL slow_frame: resp %h mem %h required 4b %h", got, dev_mem[a], d);
        end
    endtask

    task automatic test_tx_full();
        logic [7:0] a, got;
        bit ok;
        a = 8'($urandom);
        txq.delete();
        tx_full_i = 1'b1;
        push(8'h52); push(a);
        ticks(12);
        checks++;
        if (txq.size() !== 0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL txfull_hold: tx %0d busy %b required 0 1", txq.size(), busy_o);
        end
        tx_full_i = 1'b0;
        wait_tx(1, 10, ok);
        ticks(3);
        got = ok ? txq[0] : 8'hxx;
        checks++;
        if (got !== ref_mem[a] || txq.size() !== 1) begin
            errors++;
            $display("FAIL txfull_release: resp %h count %0d required %h 1",
                     got, txq.size(), ref_mem[a]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expq[$];
        logic [7:0] a, d, got;
        int kind, n, bad;
        bit ok;
        txq.delete();
        n = 16;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 2);
            a = 8'($urandom); d = 8'($urandom);
            if (kind == 0) begin
                push(8'h57); push(a); push(d);
                ref_mem[a] = d;
                expq.push_back(8'h4B);
            end else if (kind == 1) begin
                push(8'h52); push(a);
                expq.push_back(ref_mem[a]);
            end else begin
                push(bad_byte());
                ref_err = (ref_err < 255) ? ref_err + 1 : 255;
                expq.push_back(8'h3F);
            end
        end
        wait_tx(n, n * 10 + 20, ok);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            got = (i < txq.size()) ? txq[i] : 8'hxx;
            if (got !== expq[i]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_resp: %0d of %0d responses wrong, tx count %0d", bad, n, txq.size());
        end
        checks++;
        if (err_cnt_o !== 8'(ref_err) || rxq.size() !== 0) begin
            errors++;
            $display("FAIL b2b_after: err %h rxleft %0d required %h 0",
                     err_cnt_o, rxq.size(), 8'(ref_err));
        end
    endtask

    task automatic test_reset_and_saturate();
        int we0, bad;
        bit ok;
        we0 = we_cnt;
        txq.delete();
        push(8'h57); push(8'h05);
        ticks(4);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++;
        if ({rd_uart_o, wr_uart_o, reg_we_o, reg_re_o, busy_o} !== 5'b0 ||
            {w_data_o, reg_addr_o, reg_wdata_o, err_cnt_o} !== 32'h0) begin
            errors++;
            $display("FAIL midframe_reset: strobes %b data %h required 00000 00000000",
                     {rd_uart_o, wr_uart_o, reg_we_o, reg_re_o, busy_o},
                     {w_data_o, reg_addr_o, reg_wdata_o, err_cnt_o});
        end
        ref_err = 0;
        ticks(TIMEOUT + 5);
        checks++;
        if (txq.size() !== 0 || busy_o !== 1'b0 || we_cnt !== we0) begin
            errors++;
            $display("FAIL midframe_noresp: tx %0d busy %b we %0d required 0 0 0",
                     txq.size(), busy_o, we_cnt - we0);
        end
        for (int i = 0; i < 255; i++) push(bad_byte());
        wait_tx(255, 255 * 4 + 20, ok);
        checks++;
        if (err_cnt_o !== 8'hFF || !ok) begin
            errors++;
            $display("FAIL sat_reach: err %h tx %0d required ff 255", err_cnt_o, txq.size());
        end
        txq.delete();
        push(bad_byte());
        wait_tx(1, 20, ok);
        checks++;
        if (err_cnt_o !== 8'hFF || !ok || txq[0] !== 8'h3F) begin
            errors++;
            $display("FAIL sat_hold: err %h tx %0d required ff 1", err_cnt_o, txq.size());
        end
    endtask

    initial begin
        logic [7:0] v;
        reset_i     = 1'b1;
        rx_empty_i  = 1'b1;
        r_data_i    = 8'h00;
        tx_full_i   = 1'b0;
        reg_rdata_i = 8'h00;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            dev_mem[i] = v;
            ref_mem[i] = v;
        end
        @(negedge clk_i);
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_timeout();
        test_tx_full();
        test_back_to_back();
        test_reset_and_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
